// File: rtl/scheduler_acc_lookup_pkg.sv
// Shared definitions for the accelerator lookup path.
// Holds the scheduling-data word layout written by the bitinfo parser
// (task type in the low bits, then accelerator id, then instance count-1)
// and the lookup FSM state type.
package scheduler_acc_lookup_pkg;

   localparam int SCHED_TASKTYPE_BITS    = 32;
   localparam int SCHED_DATA_TASK_TYPE_L = 0;
   localparam int SCHED_DATA_TASK_TYPE_H = SCHED_DATA_TASK_TYPE_L + SCHED_TASKTYPE_BITS - 1;
   localparam int SCHED_DATA_ACCID_L     = 32;
   localparam int SCHED_DATA_COUNT_L     = 40;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_COMPARE,
      ST_RESPOND
   } LookupState_t;

endpackage

// File: rtl/scheduler_acc_lookup_rr.sv
// sched_rr_counters: one round-robin counter per scheduling-data entry.
// Ports:
//   clk, rst   clock, async active-high reset
//   clr        synchronous clear of every counter
//   idx        entry selected for both read and update
//   rr         current counter value of entry idx
//   count      instances-1 of entry idx (wrap point)
//   inc        advance counter idx, wrapping to 0 after count
module sched_rr_counters #(
   parameter int MAX_ACC_TYPES = 16,
   parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
   parameter int ACC_BITS      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [ACC_TYPE_BITS-1:0] idx,
   output logic [ACC_BITS-1:0]      rr,
   input  logic [ACC_BITS-1:0]      count,
   input  logic                     inc
);

   logic [MAX_ACC_TYPES-1:0][ACC_BITS-1:0] rr_q;

   assign rr = rr_q[idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= '0;
      end else if (clr) begin
         // stale counters would bias selection after a reconfiguration
         rr_q <= '0;
      end else if (inc) begin
         rr_q[idx] <= (rr_q[idx] == count) ? '0 : rr_q[idx] + 1'b1;
      end
   end

endmodule

// File: rtl/scheduler_acc_lookup.sv
// scheduler_acc_lookup: maps a task type to an accelerator instance.
// Scans the scheduling-data memory (port B, 1-cycle read latency) linearly
// for the first entry of the requested type and hands out its instances
// round-robin.
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_done, num_acc_types    scheduling data valid / number of entries
//   req_valid/ready/task_type  lookup request
//   scheduleData_portB_*       memory read port
//   rsp_valid/ready            response handshake
//   rsp_found/acc_id/type_idx  lookup result
module scheduler_acc_lookup
   import scheduler_acc_lookup_pkg::*;
#(
   parameter int MAX_ACCS        = 16,
   parameter int MAX_ACC_TYPES   = 16,
   parameter int ACC_TYPE_BITS   = $clog2(MAX_ACC_TYPES),
   parameter int SCHED_DATA_BITS = 48,
   localparam int ACC_BITS       = $clog2(MAX_ACCS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_done,
   input  logic [ACC_TYPE_BITS:0]         num_acc_types,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [SCHED_TASKTYPE_BITS-1:0] req_task_type,
   output logic [ACC_TYPE_BITS-1:0]       scheduleData_portB_addr,
   output logic                           scheduleData_portB_en,
   input  logic [SCHED_DATA_BITS-1:0]     scheduleData_portB_dout,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic                           rsp_found,
   output logic [ACC_BITS-1:0]            rsp_acc_id,
   output logic [ACC_TYPE_BITS-1:0]       rsp_type_idx
);

   localparam logic [ACC_TYPE_BITS:0] NUM_MAX = (ACC_TYPE_BITS+1)'(MAX_ACC_TYPES);

   LookupState_t                   state;
   logic                           idle_q;
   logic [SCHED_TASKTYPE_BITS-1:0] type_q;
   logic [ACC_TYPE_BITS-1:0]       idx;
   logic [ACC_TYPE_BITS:0]         num_q;
   logic [ACC_TYPE_BITS:0]         num_clamped;

   logic [SCHED_TASKTYPE_BITS-1:0] dout_type;
   logic [ACC_BITS-1:0]            dout_accid;
   logic [ACC_BITS-1:0]            dout_count;
   logic [ACC_BITS-1:0]            rr_val;
   logic                           hit;
   logic                           last;
   logic                           unused_dout;

   assign dout_type  = scheduleData_portB_dout[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
   assign dout_accid = scheduleData_portB_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
   assign dout_count = scheduleData_portB_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
   // upper bits of the id/count fields are ignored by design
   assign unused_dout = ^scheduleData_portB_dout;

   assign num_clamped = (num_acc_types > NUM_MAX) ? NUM_MAX : num_acc_types;
   assign hit  = (state == ST_COMPARE) && (dout_type == type_q);
   assign last = ({1'b0, idx} == num_q - 1'b1);

   // idle_q is registered so ready stays low out of reset; cfg_done gates
   // it directly so a dropped config is never accepted against
   assign req_ready = idle_q & cfg_done;

   sched_rr_counters #(
      .MAX_ACC_TYPES (MAX_ACC_TYPES),
      .ACC_TYPE_BITS (ACC_TYPE_BITS),
      .ACC_BITS      (ACC_BITS)
   ) u_rr (
      .clk   (clk),
      .rst   (rst),
      .clr   (!cfg_done),
      .idx   (idx),
      .rr    (rr_val),
      .count (dout_count),
      .inc   (hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                   <= ST_IDLE;
         idle_q                  <= 1'b0;
         type_q                  <= '0;
         idx                     <= '0;
         num_q                   <= '0;
         scheduleData_portB_en   <= 1'b0;
         scheduleData_portB_addr <= '0;
         rsp_valid               <= 1'b0;
         rsp_found               <= 1'b0;
         rsp_acc_id              <= '0;
         rsp_type_idx            <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               idle_q <= 1'b1;
               if (req_valid && req_ready) begin
                  idle_q       <= 1'b0;
                  type_q       <= req_task_type;
                  idx          <= '0;
                  num_q        <= num_clamped;
                  rsp_found    <= 1'b0;
                  rsp_acc_id   <= '0;
                  rsp_type_idx <= '0;
                  if (num_clamped == '0) begin
                     // empty table: RESPOND raises rsp_valid one edge later
                     state <= ST_RESPOND;
                  end else begin
                     scheduleData_portB_en   <= 1'b1;
                     scheduleData_portB_addr <= '0;
                     state                   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               scheduleData_portB_en <= 1'b0;
               state                 <= ST_COMPARE;
            end
            ST_COMPARE: begin
               if (hit) begin
                  rsp_found    <= 1'b1;
                  rsp_type_idx <= idx;
                  rsp_acc_id   <= dout_accid + rr_val;
                  rsp_valid    <= 1'b1;
                  state        <= ST_RESPOND;
               end else if (last) begin
                  rsp_found  <= 1'b0;
                  rsp_acc_id <= '0;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESPOND;
               end else begin
                  idx                     <= idx + 1'b1;
                  scheduleData_portB_en   <= 1'b1;
                  scheduleData_portB_addr <= idx + 1'b1;
                  state                   <= ST_ISSUE;
               end
            end
            ST_RESPOND: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  idle_q    <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scheduler_acc_lookup.sv
// Self-checking bench for scheduler_acc_lookup: directed table, corner
// sequences, then randomized configurations against a scan-and-pick model.
module tb_scheduler_acc_lookup;
   import scheduler_acc_lookup_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_done;
   logic [4:0]  num_acc_types;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_task_type;
   logic [3:0]  scheduleData_portB_addr;
   logic        scheduleData_portB_en;
   logic [47:0] scheduleData_portB_dout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_found;
   logic [3:0]  rsp_acc_id;
   logic [3:0]  rsp_type_idx;

   scheduler_acc_lookup dut (
      .clk                     (clk),
      .rst                     (rst),
      .cfg_done                (cfg_done),
      .num_acc_types           (num_acc_types),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_task_type           (req_task_type),
      .scheduleData_portB_addr (scheduleData_portB_addr),
      .scheduleData_portB_en   (scheduleData_portB_en),
      .scheduleData_portB_dout (scheduleData_portB_dout),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_found               (rsp_found),
      .rsp_acc_id              (rsp_acc_id),
      .rsp_type_idx            (rsp_type_idx)
   );

   always #5 clk = ~clk;

   logic [47:0] mem [16];
   always @(posedge clk)
      if (scheduleData_portB_en) scheduleData_portB_dout <= mem[scheduleData_portB_addr];

   int checks   = 0;
   int failures = 0;
   int rr_m [16];

   typedef struct {
      logic [31:0] t;
      bit          f;
      int          acc;
      int          ix;
      int          lat;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [47:0] ent(input int t, input int accid, input int cnt);
      return {8'(cnt), 8'(accid), 32'(t)};
   endfunction

   // Reference: first entry of the type among the first min(num,16) wins;
   // instance = (id + pick count) mod 16, pick count cycles 0..count.
   function automatic void model(input logic [31:0] t, input int num,
                                 output bit f, output int acc, output int ix, output int lat);
      int n = (num > 16) ? 16 : num;
      f = 0; acc = 0; ix = 0;
      lat = (n == 0) ? 1 : 2 * n;
      for (int k = 0; k < n; k++) begin
         if (mem[k][31:0] == t) begin
            int id  = int'(mem[k][39:32]) % 16;
            int cnt = int'(mem[k][47:40]) % 16;
            f   = 1;
            ix  = k;
            acc = (id + rr_m[k]) % 16;
            rr_m[k] = (rr_m[k] == cnt) ? 0 : rr_m[k] + 1;
            lat = 2 * k + 2;
            break;
         end
      end
   endfunction

   task automatic lookup(input logic [31:0] t, output bit ok, output logic f,
                         output logic [3:0] a, output logic [3:0] ix,
                         output int lat, output bit en_seen);
      int n = 0;
      ok = 0; f = 0; a = 0; ix = 0; lat = 0; en_seen = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready) return;
      req_valid = 1; req_task_type = t;
      @(posedge clk); #1;
      req_valid = 0;
      while (!rsp_valid && lat < 100) begin
         if (scheduleData_portB_en) en_seen = 1;
         @(posedge clk); #1; lat++;
      end
      if (!rsp_valid) return;
      ok = 1; f = rsp_found; a = rsp_acc_id; ix = rsp_type_idx;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
   endtask

   task automatic cfg_pulse();
      cfg_done = 0;
      @(posedge clk); #1;
      cfg_done = 1;
      foreach (rr_m[i]) rr_m[i] = 0;
   endtask

   task automatic run_one(input string tag, input logic [31:0] t, input int num);
      bit ok, ef, es; logic f; logic [3:0] a, ix; int lat, ea, ei, el;
      num_acc_types = 5'(num);
      model(t, num, ef, ea, ei, el);
      lookup(t, ok, f, a, ix, lat, es);
      chk({tag, "_done"}, ok, 1);
      if (ok) begin
         chk({tag, "_found"}, f, ef);
         chk({tag, "_acc"}, a, ea);
         chk({tag, "_lat"}, lat, el);
         chk({tag, "_en"}, es, (num != 0));
         if (ef) chk({tag, "_idx"}, ix, ei);
      end
      finish_rsp();
   endtask

   initial begin
      bit ok, es; logic f; logic [3:0] a, ix; int lat;
      logic sf; logic [3:0] sa, si; bit stable;

      tbl[0] = '{5, 1, 0, 0, 2};
      tbl[1] = '{5, 1, 1, 0, 2};
      tbl[2] = '{5, 1, 0, 0, 2};
      tbl[3] = '{5, 1, 1, 0, 2};
      tbl[4] = '{7, 1, 2, 1, 4};
      tbl[5] = '{9, 0, 0, 0, 4};

      rst = 1; cfg_done = 0; num_acc_types = 0; req_valid = 0;
      req_task_type = 0; rsp_ready = 0;
      foreach (mem[i]) mem[i] = '0;
      foreach (rr_m[i]) rr_m[i] = 0;
      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_found", rsp_found, 0);
      chk("rst_rsp_acc", rsp_acc_id, 0);
      chk("rst_rsp_idx", rsp_type_idx, 0);
      chk("rst_en", scheduleData_portB_en, 0);
      chk("rst_addr", scheduleData_portB_addr, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;

      // directed table
      mem[0] = ent(5, 0, 1);
      mem[1] = ent(7, 2, 0);
      num_acc_types = 2; cfg_done = 1;
      for (int i = 0; i < 6; i++) begin
         lookup(tbl[i].t, ok, f, a, ix, lat, es);
         chk("tbl_done", ok, 1);
         chk("tbl_found", f, tbl[i].f);
         chk("tbl_acc", a, tbl[i].acc);
         chk("tbl_lat", lat, tbl[i].lat);
         if (tbl[i].f) chk("tbl_idx", ix, tbl[i].ix);
         finish_rsp();
      end

      // empty table
      num_acc_types = 0;
      lookup(5, ok, f, a, ix, lat, es);
      chk("empty_done", ok, 1);
      chk("empty_found", f, 0);
      chk("empty_lat", lat, 1);
      chk("empty_no_en", es, 0);
      finish_rsp();

      // back-pressure
      num_acc_types = 2;
      lookup(7, ok, f, a, ix, lat, es);
      chk("hold_done", ok, 1);
      sf = rsp_found; sa = rsp_acc_id; si = rsp_type_idx;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         stable = rsp_valid && rsp_found == sf && rsp_acc_id == sa &&
                  rsp_type_idx == si && !req_ready;
         chk("hold_stable", stable, 1);
      end
      chk("hold_acc", sa, 2);
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("hold_release_valid", rsp_valid, 0);
      chk("hold_release_ready", req_ready, 1);

      // cfg_done drop clears round-robin state (rr[0] is 0 here)
      lookup(5, ok, f, a, ix, lat, es);
      chk("cfg_first_acc", a, 0);
      finish_rsp();
      cfg_done = 0;
      #1 chk("cfg_low_ready", req_ready, 0);
      @(posedge clk); #1;
      cfg_done = 1;
      lookup(5, ok, f, a, ix, lat, es);
      chk("cfg_cleared_acc", a, 0);
      finish_rsp();

      // async reset while comparing entry 1
      while (!req_ready) begin @(posedge clk); #1; end
      req_valid = 1; req_task_type = 7;
      @(posedge clk); #1; req_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_issue_en", scheduleData_portB_en, 1);
      chk("abort_issue_addr", scheduleData_portB_addr, 1);
      @(posedge clk); #2;
      rst = 1;
      #1;
      chk("abort_en", scheduleData_portB_en, 0);
      chk("abort_addr", scheduleData_portB_addr, 0);
      chk("abort_valid", rsp_valid, 0);
      chk("abort_ready", req_ready, 0);
      chk("abort_acc", rsp_acc_id, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      foreach (rr_m[i]) rr_m[i] = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("abort_no_rsp", rsp_valid, 0);
      end

      // id wrap
      mem[0] = ent(3, 15, 1);
      num_acc_types = 1;
      cfg_pulse();
      lookup(3, ok, f, a, ix, lat, es);
      chk("wrap_acc0", a, 15);
      finish_rsp();
      lookup(3, ok, f, a, ix, lat, es);
      chk("wrap_acc1", a, 0);
      finish_rsp();

      // randomized configurations
      for (int c = 0; c < 30; c++) begin
         int num = $urandom_range(0, 20);
         foreach (mem[i])
            mem[i] = ent($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
         if (c % 3 == 0)
            foreach (mem[i]) mem[i][47:40] = 8'($urandom_range(0, 3));
         cfg_pulse();
         for (int r = 0; r < 8; r++)
            run_one("rand", 32'($urandom_range(0, 8)), num);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
